// File: rtl/sliding_puzzle_core.sv
// ROWS x COLS sliding-tile engine: loads a start board, inserts the blank, applies one-hot
// blank moves, counts legal moves, flags rejected ones and reports a solved board.
module sliding_puzzle_core #(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 3,
    parameter int unsigned CW = 10,
    localparam int unsigned N = ROWS * COLS,
    localparam int unsigned TW = $clog2(N + 1),
    localparam int unsigned PW = $clog2(N),
    localparam int unsigned BLANK_INIT = (ROWS - 1) * COLS
) (
    input  logic              clk_d,
    input  logic              rst,
    input  logic [1:0]        game_status,
    input  logic [3:0]        act,
    input  logic [N*TW-1:0]   origin_board,
    output logic [N*TW-1:0]   out,
    output logic [PW-1:0]     blank_pos,
    output logic [CW-1:0]     move_cnt,
    output logic              illegal_move,
    output logic              win_flag
);

    typedef enum logic [1:0] {
        StChoseBoard  = 2'b00,
        StGaming      = 2'b01,
        StGameInitial = 2'b10,
        StWinned      = 2'b11
    } status_e;

    function automatic logic [N*TW-1:0] identity_board();
        logic [N*TW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            b[(N-1-i)*TW +: TW] = TW'(i);
        end
        return b;
    endfunction

    localparam logic [N*TW-1:0] IdentityBoard = identity_board();

    status_e         status;
    logic [N*TW-1:0] origin_q, origin_d;
    logic [N*TW-1:0] board_q, board_d;
    logic [PW-1:0]   blank_q, blank_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            win_q, win_d;

    assign status = status_e'(game_status);

    always_comb begin
        int unsigned pos, row, col, target;
        logic        legal;

        origin_d  = origin_q;
        board_d   = board_q;
        blank_d   = blank_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;

        pos    = 32'(blank_q);
        row    = pos / COLS;
        col    = pos % COLS;
        legal  = 1'b0;
        target = pos;

        // Lowest asserted act bit wins; the rest are ignored this cycle.
        if (act[0]) begin
            legal  = row > 0;
            target = pos - COLS;
        end else if (act[1]) begin
            legal  = col < COLS - 1;
            target = pos + 1;
        end else if (act[2]) begin
            legal  = row < ROWS - 1;
            target = pos + COLS;
        end else if (act[3]) begin
            legal  = col > 0;
            target = pos - 1;
        end

        case (status)
            StChoseBoard: origin_d = origin_board;
            StGameInitial: begin
                board_d = origin_q;
                board_d[(N-1-BLANK_INIT)*TW +: TW] = TW'(N);
                blank_d = PW'(BLANK_INIT);
                cnt_d   = '0;
            end
            StGaming: begin
                if (act != 4'b0000) begin
                    if (legal) begin
                        board_d[(N-1-pos)*TW +: TW]    = board_q[(N-1-target)*TW +: TW];
                        board_d[(N-1-target)*TW +: TW] = board_q[(N-1-pos)*TW +: TW];
                        blank_d = PW'(target);
                        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StWinned: begin
                origin_d = IdentityBoard;
                blank_d  = PW'(BLANK_INIT);
            end
            default: ;
        endcase
    end

    always_comb begin
        int unsigned blanks;
        logic        in_place;

        blanks   = 0;
        in_place = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (board_q[(N-1-i)*TW +: TW] == TW'(N)) begin
                blanks = blanks + 1;
            end else if (board_q[(N-1-i)*TW +: TW] != TW'(i)) begin
                in_place = 1'b0;
            end
        end
        win_d = in_place && (blanks == 1);
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            origin_q  <= IdentityBoard;
            board_q   <= IdentityBoard;
            blank_q   <= PW'(BLANK_INIT);
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            origin_q  <= origin_d;
            board_q   <= board_d;
            blank_q   <= blank_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            win_q     <= win_d;
        end
    end

    assign out          = board_q;
    assign blank_pos    = blank_q;
    assign move_cnt     = cnt_q;
    assign illegal_move = illegal_q;
    assign win_flag     = win_q;

endmodule
